// File: rtl/weight_bank_loader_pkg.sv
// Shared constants for the weight bank writer: FSM encoding and
// default widths matching the neuron weight register bank.
package weight_bank_loader_pkg;

  localparam int WB_DATA_W      = 8;
  localparam int WB_ADDR_W      = 2;
  localparam int WB_NUM_WEIGHTS = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/weight_bank_loader.sv
// Byte-stream to weight-bank write sequencer: writes addresses
// 0..NUM_WEIGHTS-1 in order, one registered write pulse per byte.
module weight_bank_loader
  import weight_bank_loader_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int NUM_WEIGHTS = WB_NUM_WEIGHTS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] bank_data,
  output logic [ADDR_W-1:0] bank_addr,
  output logic              bank_write,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WEIGHTS - 1);

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [ADDR_W-1:0] idx;
  logic              xfer;

  // abort kills a same-cycle transfer before it reaches the bank
  assign xfer = (state == S_LOAD) && in_valid && in_ready && !abort;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start && !abort)
          state_n = S_LOAD;
      end
      S_LOAD: begin
        if (abort)
          state_n = S_IDLE;
        else if (xfer && idx == LAST)
          state_n = S_FLUSH;
      end
      S_FLUSH: state_n = abort ? S_IDLE : S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      in_ready   <= 1'b0;
      bank_data  <= '0;
      bank_addr  <= '0;
      bank_write <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_n;
      in_ready   <= (state_n == S_LOAD);
      busy       <= (state_n == S_LOAD) || (state_n == S_FLUSH);
      done       <= (state_n == S_DONE);
      bank_write <= xfer;
      if (state == S_IDLE && state_n == S_LOAD) begin
        idx   <= '0;
        count <= '0;
      end
      if (xfer) begin
        bank_data <= in_data;
        bank_addr <= idx;
        count     <= {1'b0, idx} + {{ADDR_W{1'b0}}, 1'b1};
        if (idx != LAST)
          idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_bank_loader.sv
// Randomized bench for weight_bank_loader against a bank-content and
// write-log model; a second instance covers the single-weight build.
module tb_weight_bank_loader;

  localparam int NW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, in_valid;
  logic [7:0] in_data;
  logic       in_ready, bank_write, busy, done;
  logic [7:0] bank_data;
  logic [1:0] bank_addr;
  logic [2:0] count;

  logic       s_start, s_abort, s_in_valid;
  logic [7:0] s_in_data;
  logic       s_in_ready, s_bank_write, s_busy, s_done;
  logic [7:0] s_bank_data;
  logic [1:0] s_bank_addr;
  logic [2:0] s_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  weight_bank_loader #(.DATA_W(8), .ADDR_W(2), .NUM_WEIGHTS(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bank_data(bank_data), .bank_addr(bank_addr),
    .bank_write(bank_write), .busy(busy), .done(done), .count(count)
  );

  weight_bank_loader #(.DATA_W(8), .ADDR_W(2), .NUM_WEIGHTS(1)) dut1 (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort),
    .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .bank_data(s_bank_data),
    .bank_addr(s_bank_addr), .bank_write(s_bank_write),
    .busy(s_busy), .done(s_done), .count(s_count)
  );

  // bank side: capture exactly what a real register bank would see
  logic [7:0] bank   [4] = '{default: 8'h00};
  logic [7:0] bmodel [4] = '{default: 8'h00};
  logic [9:0] wlog[$];
  int         wcyc[$];
  logic [9:0] s_wlog[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         s_done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bank_write) begin
      bank[bank_addr] <= bank_data;
      wlog.push_back({bank_addr, bank_data});
      wcyc.push_back(cyc);
    end
    if (done)
      done_cnt <= done_cnt + 1;
    if (s_bank_write)
      s_wlog.push_back({s_bank_addr, s_bank_data});
    if (s_done)
      s_done_cnt <= s_done_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // abort_at: -1 none, 0..NW-1 abort at that byte, NW abort in FLUSH
  task automatic run_load(input logic [31:0] pat, input int gap,
                          input int abort_at, input bit glitch);
    logic [7:0] b[4];
    int m;
    int dc0;
    for (int i = 0; i < NW; i++) b[i] = pat[8*i +: 8];
    wlog.delete();
    wcyc.delete();
    @(negedge clk);
    dc0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = NW;
    for (int i = 0; i < NW; i++) begin
      check("rdy_load", in_ready, 1);
      if (i == abort_at) begin
        abort = 1'b1; in_valid = 1'b1; in_data = ~b[i];
        m = i;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        break;
      end
      in_valid = 1'b1;
      in_data  = b[i];
      start    = glitch && (i == 1);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < NW - 1)
        repeat (gap) begin
          check("rdy_gap", in_ready, 1);
          @(negedge clk);
        end
    end
    if (m == NW) begin
      check("flush_rdy", in_ready, 0);
      check("flush_busy", busy, 1);
      check("flush_wr", bank_write, 1);
      if (abort_at == NW) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    end else begin
      check("abort_rdy", in_ready, 0);
      check("abort_busy", busy, 0);
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < m; i++) bmodel[i] = b[i];
    check("idle_rdy", in_ready, 0);
    check("idle_busy", busy, 0);
    check("done_pulses", done_cnt - dc0, (abort_at < 0) ? 1 : 0);
    check("count", count, m);
    check("n_writes", wlog.size(), m);
    for (int i = 0; i < m && i < wlog.size(); i++)
      check("write", wlog[i], {i[1:0], b[i]});
    for (int i = 0; i < 4; i++)
      check("bank", bank[i], bmodel[i]);
    if (abort_at < 0 && wcyc.size() == NW)
      for (int i = 1; i < NW; i++)
        check("spacing", wcyc[i] - wcyc[i-1], gap + 1);
  endtask

  initial begin
    logic [7:0] x0, x1;
    int ab;
    reset = 1'b1;
    {start, abort, in_valid, in_data} = '0;
    {s_start, s_abort, s_in_valid, s_in_data} = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr", bank_write, 0);
    check("rst_count", count, 0);
    check("rst_data", bank_data, 0);
    check("rst_addr", bank_addr, 0);
    reset = 1'b0;

    run_load(32'h44332211, 0, -1, 1'b0);
    run_load(32'h44332211, 3, -1, 1'b0);
    run_load($urandom, 0, 2, 1'b0);
    run_load($urandom, 0, -1, 1'b0);
    run_load($urandom, 1, -1, 1'b1);

    // start together with abort while idle must do nothing
    wlog.delete();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; in_valid = 1'b1;
    check("sa_rdy", in_ready, 0);
    check("sa_busy", busy, 0);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("sa_writes", wlog.size(), 0);

    for (int k = 0; k < 20; k++) begin
      ab = $urandom_range(0, 9);
      run_load($urandom, $urandom_range(0, 3),
               (ab <= NW) ? ab : -1, 1'b0);
    end

    // asynchronous reset in the middle of a load
    wlog.delete();
    x0 = 8'($urandom); x1 = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = x0;
    @(negedge clk);
    in_data = x1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    bmodel[0] = x0; bmodel[1] = x1;
    in_valid = 1'b1; in_data = ~x1;
    #2 reset = 1'b1;
    #1;
    check("arst_rdy", in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_wr", bank_write, 0);
    check("arst_count", count, 0);
    check("arst_data", bank_data, 0);
    check("arst_addr", bank_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("arst_rdy2", in_ready, 0);
    check("arst_writes", wlog.size(), 2);
    for (int i = 0; i < 4; i++)
      check("arst_bank", bank[i], bmodel[i]);

    // single-weight build
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("one_rdy", s_in_ready, 1);
    s_in_valid = 1'b1; s_in_data = 8'hA5;
    @(negedge clk);
    s_in_valid = 1'b0;
    check("one_wr", s_bank_write, 1);
    check("one_busy", s_busy, 1);
    check("one_rdy_flush", s_in_ready, 0);
    @(negedge clk);
    check("one_done", s_done, 1);
    @(negedge clk);
    check("one_done_off", s_done, 0);
    check("one_count", s_count, 1);
    check("one_pulses", s_done_cnt, 1);
    check("one_writes", s_wlog.size(), 1);
    if (s_wlog.size() > 0)
      check("one_entry", s_wlog[0], {2'd0, 8'hA5});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
